// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the stream_demux block.
// The error counter is built only when STREAM_DEMUX_ERR_COUNT_EN is defined.
package stream_demux_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 32;
  localparam int unsigned DEFAULT_NUM_OUT   = 3;
  localparam int unsigned DEFAULT_SEL_WIDTH = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int unsigned                ERR_COUNT_WIDTH = 8;
  localparam logic [ERR_COUNT_WIDTH-1:0] ERR_COUNT_MAX   = 8'd255;

endpackage

// File: rtl/demux_channel_slot.sv
// One-entry holding register for a single demux destination channel.
// The slot is refilled in the same cycle it drains, so a FULL slot never bubbles.
module demux_channel_slot
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             drain_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      SLOT_EMPTY: begin
        if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = load_data_i;
        end
      end
      SLOT_FULL: begin
        if (load_i) begin
          data_d = load_data_i;
        end else if (drain_i) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT valid/ready demultiplexer with one holding slot per channel.
// Define STREAM_DEMUX_ERR_COUNT_EN to add the saturating out-of-range counter err_count.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned NUM_OUT   = DEFAULT_NUM_OUT,
  parameter int unsigned SEL_WIDTH = DEFAULT_SEL_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [SEL_WIDTH-1:0]       in_selector,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_OUT*WIDTH-1:0]   out_data,
  output logic [NUM_OUT-1:0]         out_valid,
  input  logic [NUM_OUT-1:0]         out_ready
`ifdef STREAM_DEMUX_ERR_COUNT_EN
  ,
  output logic [ERR_COUNT_WIDTH-1:0] err_count
`endif
);

  localparam int unsigned SelSpan = 1 << SEL_WIDTH;

  logic               sel_in_range;
  logic [SelSpan-1:0] ready_pad;
  logic [NUM_OUT-1:0] load;

  assign sel_in_range = 32'(in_selector) < NUM_OUT;

  // Unused selector codes read as ready so out-of-range words are swallowed.
  always_comb begin
    ready_pad = '1;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      ready_pad[k] = !out_valid[k] || out_ready[k];
    end
  end

  assign in_ready = !reset && ready_pad[in_selector];

  always_comb begin
    load = '0;
    if (in_valid && in_ready && sel_in_range) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        load[k] = (in_selector == SEL_WIDTH'(k));
      end
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : gen_slot
    demux_channel_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load[g]),
      .load_data_i(in_data),
      .drain_i    (out_ready[g]),
      .valid_o    (out_valid[g]),
      .data_o     (out_data[g*WIDTH +: WIDTH])
    );
  end

`ifdef STREAM_DEMUX_ERR_COUNT_EN
  logic                       accept_oor;
  logic [ERR_COUNT_WIDTH-1:0] err_count_q, err_count_d;

  assign accept_oor = in_valid && in_ready && !sel_in_range;

  always_comb begin
    err_count_d = err_count_q;
    if (accept_oor && (err_count_q != ERR_COUNT_MAX)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux against a per-channel queue scoreboard.
// Checks err_count too when STREAM_DEMUX_ERR_COUNT_EN is defined.
module tb_stream_demux;

  localparam int unsigned W = 32;
  localparam int unsigned N = 3;

  logic             clk;
  logic             reset;
  logic [W-1:0]     in_data;
  logic [1:0]       in_selector;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   out_data;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;
`ifdef STREAM_DEMUX_ERR_COUNT_EN
  logic [7:0]       err_count;
`endif

  stream_demux #(
    .WIDTH    (W),
    .NUM_OUT  (N),
    .SEL_WIDTH(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_selector(in_selector),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef STREAM_DEMUX_ERR_COUNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [W-1:0] word_q_t[$];
  word_q_t exp_q [N];
  int      exp_err;
  int      n_vec;
  int      n_err;

  task automatic clear_model();
    for (int k = 0; k < N; k++) exp_q[k].delete();
    exp_err = 0;
  endtask

  // One cycle: drive at the falling edge, compare 1 time unit later, update the model, advance.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] s,
                      input logic [N-1:0] rdy, output logic accepted);
    logic exp_rdy;
    int   si;
    si          = int'(s);
    in_valid    = v;
    in_data     = d;
    in_selector = s;
    out_ready   = rdy;
    #1;
    if (si >= N) exp_rdy = 1'b1;
    else         exp_rdy = (exp_q[si].size() == 0) || rdy[si];
    n_vec++;
    if (in_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL in_ready sel=%0d got %b want %b at %0t", si, in_ready, exp_rdy, $time);
    end
    for (int k = 0; k < N; k++) begin
      n_vec++;
      if (out_valid[k] !== (exp_q[k].size() != 0)) begin
        n_err++;
        $display("FAIL out_valid[%0d] got %b want %b at %0t", k, out_valid[k],
                 exp_q[k].size() != 0, $time);
      end
      if (exp_q[k].size() != 0) begin
        n_vec++;
        if (out_data[k*W +: W] !== exp_q[k][0]) begin
          n_err++;
          $display("FAIL out_data[%0d] got %h want %h at %0t", k, out_data[k*W +: W],
                   exp_q[k][0], $time);
        end
      end
    end
`ifdef STREAM_DEMUX_ERR_COUNT_EN
    n_vec++;
    if (err_count !== 8'(exp_err)) begin
      n_err++;
      $display("FAIL err_count got %0d want %0d at %0t", err_count, exp_err, $time);
    end
`endif
    accepted = v && exp_rdy;
    for (int k = 0; k < N; k++) begin
      if (exp_q[k].size() != 0 && rdy[k]) void'(exp_q[k].pop_front());
    end
    if (accepted) begin
      if (si < N) exp_q[si].push_back(d);
      else if (exp_err < 255) exp_err++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    logic a;
    step(1'b0, '0, 2'd0, 3'b111, a);
    step(1'b0, '0, 2'd0, 3'b111, a);
  endtask

  task automatic test_reset();
    logic a;
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_selector = '0; out_ready = '0;
    clear_model();
    @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 3'b000) begin
      n_err++; $display("FAIL reset_out_valid got %b want 000", out_valid);
    end
    n_vec++;
    if (out_data !== '0) begin
      n_err++; $display("FAIL reset_out_data got %h want 0", out_data);
    end
    reset = 1'b0;
    @(negedge clk);
    step(1'b1, 32'h1234_5678, 2'd1, 3'b000, a);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 3'b000) begin
      n_err++; $display("FAIL async_reset_out_valid got %b want 000", out_valid);
    end
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < N; s++) step(1'b0, '0, 2'(s), 3'b000, a);
  endtask

  task automatic test_single_routing();
    logic a;
    step(1'b1, 32'hDEAD_BEEF, 2'd2, 3'b000, a);
    step(1'b1, 32'hCAFE_F00D, 2'd2, 3'b000, a);
    step(1'b1, 32'hCAFE_F00D, 2'd2, 3'b000, a);
    step(1'b1, 32'hCAFE_F00D, 2'd2, 3'b100, a);
    drain();
  endtask

  task automatic test_back_to_back();
    logic a;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, W'(i), 2'd1, 3'b010, a);
      n_vec++;
      if (a !== 1'b1) begin
        n_err++; $display("FAIL b2b_accept word=%0d got %b want 1", i, a);
      end
    end
    drain();
  endtask

  task automatic test_independence();
    logic a;
    step(1'b1, 32'h0000_0011, 2'd0, 3'b000, a);
    step(1'b1, 32'h0000_00A5, 2'd1, 3'b000, a);
    step(1'b0, '0, 2'd0, 3'b000, a);
    drain();
  endtask

  task automatic test_out_of_range();
    logic a;
    step(1'b1, 32'h0000_0055, 2'd3, 3'b000, a);
    step(1'b0, '0, 2'd0, 3'b000, a);
    for (int i = 0; i < 300; i++) step(1'b1, W'(i), 2'd3, 3'b000, a);
    step(1'b0, '0, 2'd0, 3'b000, a);
`ifdef STREAM_DEMUX_ERR_COUNT_EN
    n_vec++;
    if (err_count !== 8'd255) begin
      n_err++; $display("FAIL err_count_saturate got %0d want 255", err_count);
    end
`endif
  endtask

  task automatic test_random();
    logic         a;
    logic         hold;
    logic         v;
    logic [W-1:0] d;
    logic [1:0]   s;
    hold = 1'b0;
    v = 1'b0; d = '0; s = '0;
    for (int c = 0; c < 10000; c++) begin
      // A stalled source must keep offering the same word.
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        d = $urandom;
        s = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      end
      step(v, d, s, 3'($urandom), a);
      hold = v && !a;
    end
    drain();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_routing();
    test_back_to_back();
    test_independence();
    test_out_of_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
